// File: rtl/swc_pkg.sv
// Shared types and constants for the serial word collector.
// Optional parity stage is enabled by defining SWC_PARITY_EN.
package swc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } swc_state_e;

    localparam int SWC_WIDTH = 4;
    localparam int SWC_DEPTH = 2;

endpackage

// File: rtl/swc_fifo2.sv
// Two-entry synchronous word buffer; a push into a full buffer is taken
// when a pop happens on the same edge.
module swc_fifo2 #(
    parameter int WIDTH = swc_pkg::SWC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [1:0][WIDTH-1:0] mem;
    logic                  wptr;
    logic                  rptr;
    logic [1:0]            count;
    logic                  wr_en;
    logic                  rd_en;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign rd_en = pop && !empty;
    // When full, the write slot equals the slot being popped this edge.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (rd_en)
                rptr <= ~rptr;
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial bits into WIDTH-bit words behind a 2-entry buffer.
// Define SWC_PARITY_EN to take a trailing even-parity bit per word.
module serial_word_collector
    import swc_pkg::*;
#(
    parameter int WIDTH = SWC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
`ifdef SWC_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    swc_state_e       state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             perr_nxt;

    assign pop        = word_valid && word_ready;
    assign word_valid = !empty;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        push      = 1'b0;
        perr_nxt  = 1'b0;
        if (bit_valid) begin
            case (state)
                IDLE: begin
                    acc_nxt   = {bit_in, acc[WIDTH-1:1]};
                    cnt_nxt   = CW'(1);
                    state_nxt = COLLECT;
                end
                COLLECT: begin
                    acc_nxt = {bit_in, acc[WIDTH-1:1]};
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef SWC_PARITY_EN
                        cnt_nxt   = CW'(WIDTH);
                        state_nxt = PARITY;
`else
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                        push      = 1'b1;
`endif
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
`ifdef SWC_PARITY_EN
                PARITY: begin
                    // acc already holds the full word; the parity bit is not shifted in.
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if ((^acc ^ bit_in) == 1'b0)
                        push = 1'b1;
                    else
                        perr_nxt = 1'b1;
                end
`endif
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            busy  <= (cnt_nxt != '0);
            if (push && full && !pop)
                overrun <= 1'b1;
        end
    end

`ifdef SWC_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            parity_err <= 1'b0;
        else
            parity_err <= perr_nxt;
    end
`else
    logic unused_perr;
    assign unused_perr = perr_nxt;
`endif

    swc_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (acc_nxt),
        .dout  (word_out),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed plus random bench for serial_word_collector with a queue-based model.
// Build with SWC_PARITY_EN defined to exercise the parity variant.
module tb_serial_word_collector;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic         busy;
    logic         overrun;
`ifdef SWC_PARITY_EN
    logic         parity_err;
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif

    int npass = 0;
    int ntot  = 0;

    // Model: pending bits, buffer contents, sticky flag, parity pulse.
    bit           mbits[$];
    logic [W-1:0] mfifo[$];
    bit           m_ovr;
    bit           m_perr;

    always #5 clk = ~clk;

    serial_word_collector #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
`ifdef SWC_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void model_edge(input bit r, input bit v, input bit b, input bit rdy);
        bit popped;
        bit ok;
        logic [W-1:0] w;
        if (r) begin
            mbits.delete(); mfifo.delete(); m_ovr = 0; m_perr = 0;
            return;
        end
        m_perr = 0;
        popped = (mfifo.size() > 0) && rdy;
        if (popped) void'(mfifo.pop_front());
        if (v) begin
            mbits.push_back(b);
            if (mbits.size() == NBITS) begin
                w = '0;
                ok = 1;
                for (int i = 0; i < W; i++) w[i] = mbits[i];
`ifdef SWC_PARITY_EN
                ok = ((^w) ^ mbits[W]) == 1'b0;
                m_perr = !ok;
`endif
                mbits.delete();
                if (ok) begin
                    if (mfifo.size() < 2) mfifo.push_back(w);
                    else m_ovr = 1;
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"}, word_valid, mfifo.size() > 0);
        check({tag, ".busy"}, busy, mbits.size() != 0);
        check({tag, ".ovr"}, overrun, m_ovr);
        if (mfifo.size() > 0) check({tag, ".word"}, word_out, mfifo[0]);
`ifdef SWC_PARITY_EN
        check({tag, ".perr"}, parity_err, m_perr);
`endif
    endtask

    // Drive inputs, clock once, update model, check at the falling edge.
    task automatic step(input bit r, input bit v, input bit b, input bit rdy, input string tag);
        rst = r; bit_valid = v; bit_in = b; word_ready = rdy;
        @(posedge clk);
        model_edge(r, v, b, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy, input string tag);
        for (int i = 0; i < W; i++) step(0, 1, w[i], rdy, tag);
`ifdef SWC_PARITY_EN
        step(0, 1, ^w, rdy, tag);
`endif
    endtask

    initial begin
        rst = 1; bit_valid = 0; bit_in = 0; word_ready = 0;
        @(negedge clk);
        step(1, 0, 0, 0, "reset");
        check("reset.word_out", word_out, '0);
        check("reset.valid0", word_valid, 1'b0);

        // 1,0,1,1 LSB first -> 4'b1101
        send_word(4'b1101, 1, "basic");
        check("basic.word", word_out, 4'b1101);
        check("basic.valid1", word_valid, 1'b1);
        step(0, 0, 0, 1, "basic.pop");
        check("basic.valid_drop", word_valid, 1'b0);

        // Partial word discarded by reset
        step(0, 1, 1, 1, "midrst");
        step(0, 1, 0, 1, "midrst");
        step(1, 0, 0, 1, "midrst.rst");
        send_word(4'b0110, 1, "midrst.w");
        check("midrst.word", word_out, 4'b0110);
        step(0, 0, 0, 1, "midrst.pop");

        // Back-pressure: A,5 kept, F dropped
        send_word(4'hA, 0, "bp");
        send_word(4'h5, 0, "bp");
        send_word(4'hF, 0, "bp");
        check("bp.overrun", overrun, 1'b1);
        check("bp.head", word_out, 4'hA);
        step(0, 0, 0, 1, "bp.popA");
        check("bp.second", word_out, 4'h5);
        step(0, 0, 0, 1, "bp.pop5");
        check("bp.empty", word_valid, 1'b0);

        // Full buffer, pop on the same edge the third word completes
        step(1, 0, 0, 0, "same.rst");
        send_word(4'h3, 0, "same");
        send_word(4'h9, 0, "same");
        for (int i = 0; i < NBITS - 1; i++) step(0, 1, (i < W) ? 1'b1 : 1'b0, 0, "same");
`ifdef SWC_PARITY_EN
        step(0, 1, 1'b0, 1, "same.last");
`else
        step(0, 1, 1'b1, 1, "same.last");
`endif
        check("same.noovr", overrun, 1'b0);
        check("same.head", word_out, 4'h9);
        step(0, 0, 0, 1, "same.pop9");
        check("same.third", word_out, 4'hF);
        step(0, 0, 0, 1, "same.popF");

        // Gaps between valid bits: 1,_,_,_,1,0,0 -> 4'b0011
        step(0, 1, 1, 1, "gap");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "gap.idle");
        step(0, 1, 1, 1, "gap");
        step(0, 1, 0, 1, "gap");
        step(0, 1, 0, 1, "gap");
`ifdef SWC_PARITY_EN
        step(0, 1, 0, 1, "gap.par");
`endif
        check("gap.word", word_out, 4'b0011);
        step(0, 0, 0, 1, "gap.pop");

`ifdef SWC_PARITY_EN
        // Bad parity: no push, one-cycle error pulse
        for (int i = 0; i < W; i++) step(0, 1, 4'b1101 >> i, 1, "perr");
        step(0, 1, 0, 1, "perr.par");
        check("perr.pulse", parity_err, 1'b1);
        check("perr.nopush", word_valid, 1'b0);
        step(0, 0, 0, 1, "perr.after");
        check("perr.clear", parity_err, 1'b0);
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 1), ($urandom_range(0, 9) < 4), "rand");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
